board_capture: RTL and testbench
================================

Name: board_capture

Overview:
- Upstream stage of the board-full detector: it converts nine raw, bouncing cell push-buttons (A..I) into clean, latched per-cell "taken" flags.
- Those flags are the nine switch inputs of the board-full AND tree.
- It also assigns each accepted move to the current player (X/O), alternates turns, and rejects illegal presses.
- The game controller drives it through clear_board and lock inputs.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronized input must differ from its debounced level before the level flips (min 2).
- CNT_W, 5, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- raw_sw  in  9  raw buttons; bit0=A ... bit8=I; 1=pressed; asynchronous to clk.
- clear_board  in  1  synchronous new-game clear, level-sensitive.
- lock  in  1  1=game over, accept no moves.
- cell_taken  out  9  1=cell claimed; bit i feeds switchA..switchI.
- cell_owner  out  9  owner of a claimed cell, 0=X, 1=O; 0 when cell not taken.
- turn  out  1  player whose move is next, 0=X.
- move_valid  out  1  one-cycle pulse: move accepted.
- move_reject  out  1  one-cycle pulse: press on taken cell, or press while locked.
- move_idx  out  4  index 0..8 of the last accepted or rejected press; held between events.

Behaviour:
- Reset (rst_n=0, async): all sync flops, debounce counters and debounced levels = 0; cell_taken=0, cell_owner=0, turn=0, move_valid=0, move_reject=0, move_idx=0.
- Synchronizer: each raw_sw bit passes through 2 flops before any use.
- Debounce, per bit:
  - When the synchronized value equals the debounced level, counter = 0.
  - Otherwise the counter increments. When counter == DEBOUNCE_CYCLES-1 and the values still differ, the debounced level flips and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is filtered out.
- Press event: rising edge of a debounced level, detected against a registered copy. Falling edges (release) are ignored.
- Arbitration when several press events occur in one cycle:
  - Only the lowest index is processed; the others are dropped.
  - No retry: those buttons must be released and pressed again.
- Processing of the selected event, registered, so outputs update at the next edge:
  - lock=1 -> move_reject=1, move_idx=i, no state change.
  - cell_taken[i]=1 -> move_reject=1, move_idx=i, no state change.
  - Otherwise -> cell_taken[i]=1, cell_owner[i]=turn, turn toggles, move_valid=1, move_idx=i.
- Latency: a raw press that is stable from clock edge 0 gives move_valid high after edge DEBOUNCE_CYCLES+3.
- clear_board=1:
  - On the next edge: cell_taken=0, cell_owner=0, turn=0, move_valid=0, move_reject=0.
  - Press events in that cycle are discarded. Debouncers keep running, so a button held through the clear does not re-fire.
  - clear_board has priority over lock and over press events.
- Full board: after 9 accepted moves, turn=1 (X always moves first, so X made 5 moves). Further presses are rejected through the taken-cell rule even if lock=0.
- move_valid and move_reject are never high in the same cycle, and neither stays high for 2 consecutive cycles unless two separate events occur.

Decomposition:
- Shared package: NUM_CELLS=9, PLAYER_X=0, PLAYER_O=1, the cell index constants CELL_A..CELL_I (0..8), and the move_idx width.
- One natural sub-module: switch_debounce (2-flop sync + counter + debounced level + rise pulse), parameterized by DEBOUNCE_CYCLES/CNT_W and instantiated 9 times.
- The top level holds the priority picker and the board/turn registers.

Test Plan:
- Reset, DEBOUNCE_CYCLES=4: hold rst_n=0 while toggling raw_sw -> every output is 0. Release rst_n, raise raw_sw[4] stable -> move_valid pulse after edge 7, move_idx=4, cell_taken=9'h010, cell_owner=0, turn=1.
- Bounce filter: raw_sw[0] toggles with 1-3 cycle pulses for 20 cycles, then holds high -> exactly one move_valid, with move_idx=0, only after the input has been stable for 4 debounced cycles.
- Re-press taken cell 4 -> move_reject pulse, move_idx=4, cell_taken and turn unchanged.
- Simultaneous stable presses of bits 2 and 7 -> move_valid with move_idx=2 only; cell 7 stays free until bit 7 is released and pressed again.
- Fill all 9 cells in order A..I -> cell_taken=9'h1FF, cell_owner=9'b010101010, turn=1. A tenth press gives move_reject. Then clear_board for 1 cycle -> cell_taken=0, turn=0.
- lock=1, press free cell 3 -> move_reject, cell 3 stays free. Drop lock and press cell 3 again -> move_valid. Then assert rst_n=0 mid-debounce -> all outputs 0 immediately (asynchronously).

Source files
------------

// File: rtl/board_capture_pkg.sv
// Shared constants for the board capture block: cell count, player encoding,
// cell index names and the width of the move index.
package board_capture_pkg;

    localparam int NUM_CELLS = 9;
    localparam int IDX_W     = 4;

    localparam logic PLAYER_X = 1'b0;
    localparam logic PLAYER_O = 1'b1;

    localparam logic [IDX_W-1:0] CELL_A = 4'd0;
    localparam logic [IDX_W-1:0] CELL_B = 4'd1;
    localparam logic [IDX_W-1:0] CELL_C = 4'd2;
    localparam logic [IDX_W-1:0] CELL_D = 4'd3;
    localparam logic [IDX_W-1:0] CELL_E = 4'd4;
    localparam logic [IDX_W-1:0] CELL_F = 4'd5;
    localparam logic [IDX_W-1:0] CELL_G = 4'd6;
    localparam logic [IDX_W-1:0] CELL_H = 4'd7;
    localparam logic [IDX_W-1:0] CELL_I = 4'd8;

endpackage

// File: rtl/board_capture_if.sv
// Button/board bundle between the game controller side and board_capture.
interface board_capture_if;
    import board_capture_pkg::*;

    logic [NUM_CELLS-1:0] raw_sw;
    logic                 clear_board;
    logic                 lock;
    logic [NUM_CELLS-1:0] cell_taken;
    logic [NUM_CELLS-1:0] cell_owner;
    logic                 turn;
    logic                 move_valid;
    logic                 move_reject;
    logic [IDX_W-1:0]     move_idx;

    modport slave (
        input  raw_sw, clear_board, lock,
        output cell_taken, cell_owner, turn, move_valid, move_reject, move_idx
    );

    modport master (
        output raw_sw, clear_board, lock,
        input  cell_taken, cell_owner, turn, move_valid, move_reject, move_idx
    );

endinterface

// File: rtl/board_capture_switch_debounce.sv
// One push-button conditioner: 2-flop synchronizer, consecutive-cycle debounce
// counter, debounced level and a single-cycle press (rising edge) pulse.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_q <= level;
            // Any sample matching the current level restarts the stability count.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/board_capture.sv
// Debounces nine cell buttons, picks the lowest simultaneous press and keeps
// the per-cell taken/owner flags and the X/O turn.
module board_capture
    import board_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    board_capture_if.slave  bus
);

    localparam logic [IDX_W-1:0] CELL_IDX [NUM_CELLS] =
        '{CELL_A, CELL_B, CELL_C, CELL_D, CELL_E, CELL_F, CELL_G, CELL_H, CELL_I};

    logic [NUM_CELLS-1:0] rise;
    logic                 pick_any;
    logic [IDX_W-1:0]     pick_idx;

    logic [NUM_CELLS-1:0] taken;
    logic [NUM_CELLS-1:0] owner;
    logic                 turn_r;
    logic                 valid_r;
    logic                 reject_r;
    logic [IDX_W-1:0]     idx_r;

    for (genvar g = 0; g < NUM_CELLS; g++) begin : g_db
        switch_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (bus.raw_sw[g]),
            .rise  (rise[g])
        );
    end

    // Lowest index wins; losing presses are dropped and must be re-pressed.
    always_comb begin
        pick_any = |rise;
        pick_idx = CELL_A;
        for (int i = NUM_CELLS - 1; i >= 0; i--) begin
            if (rise[i]) begin
                pick_idx = CELL_IDX[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken    <= '0;
            owner    <= '0;
            turn_r   <= PLAYER_X;
            valid_r  <= 1'b0;
            reject_r <= 1'b0;
            idx_r    <= '0;
        end else begin
            valid_r  <= 1'b0;
            reject_r <= 1'b0;
            if (bus.clear_board) begin
                taken  <= '0;
                owner  <= '0;
                turn_r <= PLAYER_X;
            end else if (pick_any) begin
                idx_r <= pick_idx;
                if (bus.lock || taken[pick_idx]) begin
                    reject_r <= 1'b1;
                end else begin
                    taken[pick_idx] <= 1'b1;
                    owner[pick_idx] <= turn_r;
                    turn_r          <= (turn_r == PLAYER_X) ? PLAYER_O : PLAYER_X;
                    valid_r         <= 1'b1;
                end
            end
        end
    end

    assign bus.cell_taken  = taken;
    assign bus.cell_owner  = owner;
    assign bus.turn        = turn_r;
    assign bus.move_valid  = valid_r;
    assign bus.move_reject = reject_r;
    assign bus.move_idx    = idx_r;

endmodule

// File: tb/tb_board_capture.sv
// Directed bench for board_capture: expected move events go into a queue and a
// negedge monitor checks every move_valid/move_reject pulse against it.
module tb_board_capture;
    import board_capture_pkg::*;

    localparam int DB = 4;

    typedef struct {
        bit         is_valid;
        logic [3:0] idx;
        logic [8:0] taken;
        logic [8:0] owner;
        logic       turn;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    board_capture_if bus();

    board_capture #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    logic [8:0] m_taken = '0;
    logic [8:0] m_owner = '0;
    logic       m_turn  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected outcome of a press on cell i, from the reference board state.
    task automatic expect_press(input int i);
        exp_t e;
        e.idx = 4'(i);
        if (bus.lock || m_taken[i]) begin
            e.is_valid = 1'b0;
        end else begin
            e.is_valid  = 1'b1;
            m_taken[i]  = 1'b1;
            m_owner[i]  = m_turn;
            m_turn      = ~m_turn;
        end
        e.taken = m_taken;
        e.owner = m_owner;
        e.turn  = m_turn;
        sb.push_back(e);
    endtask

    task automatic press(input int i);
        expect_press(i);
        bus.raw_sw[i] = 1'b1;
        tick(DB + 6);
        bus.raw_sw[i] = 1'b0;
        tick(DB + 6);
    endtask

    task automatic clear_pulse();
        bus.clear_board = 1'b1;
        tick(1);
        bus.clear_board = 1'b0;
        m_taken = '0;
        m_owner = '0;
        m_turn  = 1'b0;
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.move_valid && bus.move_reject)
                check("valid_and_reject", 32'd1, 32'd0);
            if (bus.move_valid || bus.move_reject) begin
                if (sb.size() == 0) begin
                    check("unexpected_event", {27'd0, bus.move_valid, bus.move_idx}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("event", {bus.move_valid, bus.move_idx, bus.cell_taken, bus.cell_owner, bus.turn},
                          {e.is_valid, e.idx, e.taken, e.owner, e.turn});
                end
            end
        end
    end

    initial begin
        bus.raw_sw      = '0;
        bus.clear_board = 1'b0;
        bus.lock        = 1'b0;

        // Reset held while buttons chatter.
        for (int k = 0; k < 12; k++) begin
            bus.raw_sw = 9'($urandom);
            tick(1);
        end
        check("reset_outputs", {bus.cell_taken, bus.cell_owner, bus.turn, bus.move_valid,
                                bus.move_reject, bus.move_idx}, 32'd0);
        bus.raw_sw = '0;
        tick(2);
        rst_n = 1'b1;
        tick(3);

        // Latency: stable press from edge 0 gives move_valid after edge DB+3.
        @(posedge clk); #1;
        bus.raw_sw[4] = 1'b1;
        expect_press(4);
        tick(DB + 2);
        check("latency_early", {31'd0, bus.move_valid}, 32'd0);
        tick(1);
        check("latency_valid", {31'd0, bus.move_valid}, 32'd1);
        check("latency_state", {bus.move_idx, bus.cell_taken, bus.cell_owner, bus.turn},
                               {4'd4, 9'h010, 9'h000, 1'b1});
        tick(DB + 6);
        bus.raw_sw[4] = 1'b0;
        tick(DB + 6);

        // Bounce: high/low bursts of 1..3 cycles, then a stable hold.
        begin
            int durs[10] = '{1, 2, 3, 1, 2, 3, 1, 2, 3, 2};
            for (int k = 0; k < 10; k++) begin
                bus.raw_sw[0] = (k % 2 == 0);
                tick(durs[k]);
            end
        end
        check("bounce_filtered", {23'd0, bus.cell_taken}, 32'h010);
        bus.raw_sw[0] = 1'b1;
        expect_press(0);
        tick(DB + 2);
        check("bounce_early", {31'd0, bus.cell_taken[0]}, 32'd0);
        tick(1);
        check("bounce_taken", {31'd0, bus.cell_taken[0]}, 32'd1);
        tick(DB + 6);
        bus.raw_sw[0] = 1'b0;
        tick(DB + 6);

        // Re-press of a taken cell.
        press(4);
        check("repress_state", {bus.cell_taken, bus.turn}, {9'h011, 1'b0});

        // Simultaneous presses: only the lowest index is served.
        bus.raw_sw[2] = 1'b1;
        bus.raw_sw[7] = 1'b1;
        expect_press(2);
        tick(DB + 6);
        bus.raw_sw[2] = 1'b0;
        bus.raw_sw[7] = 1'b0;
        tick(DB + 6);
        check("simul_cell7_free", {31'd0, bus.cell_taken[7]}, 32'd0);
        press(7);
        check("repress7_taken", {31'd0, bus.cell_taken[7]}, 32'd1);

        // Fill the board A..I from empty.
        clear_pulse();
        check("clear_state", {bus.cell_taken, bus.cell_owner, bus.turn}, 32'd0);
        for (int i = 0; i < NUM_CELLS; i++) press(i);
        check("full_board", {bus.cell_taken, bus.cell_owner, bus.turn},
                            {9'h1FF, 9'b010101010, 1'b1});
        press(5);
        clear_pulse();
        check("clear_after_full", {bus.cell_taken, bus.cell_owner, bus.turn}, 32'd0);

        // Lock rejects a free cell; unlocked retry is accepted.
        bus.lock = 1'b1;
        press(3);
        check("lock_cell3_free", {31'd0, bus.cell_taken[3]}, 32'd0);
        bus.lock = 1'b0;
        press(3);
        check("unlock_cell3", {bus.cell_taken, bus.turn}, {9'h008, 1'b1});

        // Asynchronous reset in the middle of a debounce.
        bus.raw_sw[5] = 1'b1;
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {bus.cell_taken, bus.cell_owner, bus.turn, bus.move_valid,
                              bus.move_reject, bus.move_idx}, 32'd0);
        bus.raw_sw = '0;
        tick(3);
        check("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
